// File: rtl/accel_widget.sv
// Per-axis sprite position engine: button-driven acceleration or autonomous bounce,
// stepping once per frame tick, with a combinational hit test against the scan position.
module accel_widget #(
  parameter int XW            = 11,
  parameter int RIGHT_BORDER  = 799,
  parameter int BOTTOM_BORDER = 599,
  parameter int INIT_X        = 384,
  parameter int INIT_Y        = 284,
  parameter int SPEED_MIN     = 1,
  parameter int SPEED_MAX     = 8,
  parameter int SPEED_W       = 5,
  parameter int ACCEL_TICKS   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               load,
  input  logic [XW-1:0]      firstX,
  input  logic [XW-1:0]      firstY,
  input  logic [8:0]         xSize,
  input  logic [8:0]         ySize,
  input  logic [XW-1:0]      X,
  input  logic [XW-1:0]      Y,
  output logic [XW-1:0]      myX,
  output logic [XW-1:0]      myY,
  output logic [SPEED_W-1:0] speedX,
  output logic [SPEED_W-1:0] speedY,
  output logic               atLeft,
  output logic               atRight,
  output logic               atTop,
  output logic               atBottom,
  output logic               yes
);

  localparam int SW   = XW + 2;
  localparam int HC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic signed [SW-1:0] BX = SW'(RIGHT_BORDER);
  localparam logic signed [SW-1:0] BY = SW'(BOTTOM_BORDER);

  typedef enum logic [1:0] {IDLE = 2'd0, NEG = 2'd1, POS = 2'd2} dir_t;

  typedef struct packed {
    logic [XW-1:0]      p;
    dir_t               st;
    logic [SPEED_W-1:0] spd;
    logic [HC_W-1:0]    hc;
  } axis_t;

  axis_t ax_x, ax_y;

  function automatic axis_t axis_next(input axis_t cur, input logic [8:0] s,
                                      input logic signed [SW-1:0] b, input logic bounce,
                                      input logic neg, input logic pos);
    axis_t                nx;
    dir_t                 req;
    dir_t                 dir;
    logic signed [SW-1:0] se, pmax, pe, step, t, np;
    nx   = cur;
    dir  = IDLE;
    step = '0;
    t    = '0;
    se   = $signed(SW'(s));
    pe   = $signed({2'b00, cur.p});
    pmax = (se > b) ? '0 : b - se;
    req  = (neg && !pos) ? NEG : ((pos && !neg) ? POS : IDLE);
    if (bounce) begin
      dir    = (cur.st == NEG) ? NEG : POS;
      step   = SW'(SPEED_MIN);
      nx.spd = SPEED_W'(SPEED_MIN);
      nx.hc  = '0;
    end else if (req != cur.st) begin
      dir    = req;
      nx.st  = req;
      nx.spd = SPEED_W'(SPEED_MIN);
      nx.hc  = '0;
      step   = (req == IDLE) ? '0 : SW'(SPEED_MIN);
    end else if (cur.st != IDLE) begin
      dir  = cur.st;
      step = SW'(cur.spd);
      if (cur.hc == HC_W'(ACCEL_TICKS - 1)) begin
        nx.hc  = '0;
        nx.spd = (cur.spd >= SPEED_W'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX) : cur.spd + SPEED_W'(1);
      end else begin
        nx.hc = cur.hc + HC_W'(1);
      end
    end else begin
      dir = IDLE;
    end
    // Clamp against the border; position arithmetic is wide enough never to wrap.
    case (dir)
      NEG: begin
        t  = pe - step;
        np = (t < 0) ? '0 : t;
      end
      POS: begin
        t  = pe + step;
        np = (t > pmax) ? pmax : t;
      end
      default: np = pe;
    endcase
    nx.p = np[XW-1:0];
    if (bounce) begin
      if (dir == NEG && np == '0) nx.st = POS;
      else if (dir == POS && np == pmax) nx.st = NEG;
      else nx.st = dir;
    end
    return nx;
  endfunction

  // Axis state registers: load overrides enable, motion only on enabled ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ax_x <= '{p: XW'(INIT_X), st: IDLE, spd: SPEED_W'(SPEED_MIN), hc: '0};
      ax_y <= '{p: XW'(INIT_Y), st: IDLE, spd: SPEED_W'(SPEED_MIN), hc: '0};
    end else if (load) begin
      ax_x <= '{p: firstX, st: IDLE, spd: SPEED_W'(SPEED_MIN), hc: '0};
      ax_y <= '{p: firstY, st: IDLE, spd: SPEED_W'(SPEED_MIN), hc: '0};
    end else if (enable && tick) begin
      ax_x <= axis_next(ax_x, xSize, BX, mode[0], left, right);
      ax_y <= axis_next(ax_y, ySize, BY, mode[1], up, down);
    end else begin
      ax_x <= ax_x;
      ax_y <= ax_y;
    end
  end

  logic [XW:0] x_end, y_end;

  assign myX    = ax_x.p;
  assign myY    = ax_y.p;
  assign speedX = ax_x.spd;
  assign speedY = ax_y.spd;

  assign atLeft   = (ax_x.p == '0);
  assign atTop    = (ax_y.p == '0);
  assign atRight  = ($signed({2'b00, ax_x.p}) == BX - $signed(SW'(xSize)));
  assign atBottom = ($signed({2'b00, ax_y.p}) == BY - $signed(SW'(ySize)));

  assign x_end = {1'b0, ax_x.p} + (XW+1)'(xSize);
  assign y_end = {1'b0, ax_y.p} + (XW+1)'(ySize);
  assign yes   = (X >= ax_x.p) && ({1'b0, X} <= x_end) &&
                 (Y >= ax_y.p) && ({1'b0, Y} <= y_end);

endmodule

// File: tb/tb_accel_widget.sv
// Scoreboard bench for accel_widget: a reference model predicts each cycle's state,
// expectations are queued at drive time and popped after the clock edge.
module tb_accel_widget;
  localparam int RB = 799, BB = 599, SMIN = 1, SMAX = 8, ACC = 4;

  logic        clk = 1'b0, reset = 1'b0, tick = 1'b0, enable = 1'b1, load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [10:0] firstX = 11'd0, firstY = 11'd0, X = 11'd384, Y = 11'd284;
  logic [8:0]  xSize = 9'd20, ySize = 9'd20;
  logic [10:0] myX, myY;
  logic [4:0]  speedX, speedY;
  logic        atLeft, atRight, atTop, atBottom, yes;

  accel_widget dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .mode(mode),
    .up(up), .down(down), .left(left), .right(right), .load(load),
    .firstX(firstX), .firstY(firstY), .xSize(xSize), .ySize(ySize), .X(X), .Y(Y),
    .myX(myX), .myY(myY), .speedX(speedX), .speedY(speedY),
    .atLeft(atLeft), .atRight(atRight), .atTop(atTop), .atBottom(atBottom), .yes(yes)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int sx; int sy;} exp_t;
  exp_t sbq[$];
  int nerr = 0, nchk = 0;
  int mx, my, sx, sy, hx, hy, stx, sty;

  task automatic check(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 384; my = 284; sx = SMIN; sy = SMIN; hx = 0; hy = 0; stx = 0; sty = 0;
  endtask

  // Direction codes: 0 idle, 1 toward zero, 2 toward the border.
  task automatic model_axis(input int p, input int s, input int b, input int bnc,
                            input int ng, input int ps, input int st, input int spd,
                            input int hc, output int np, output int nst,
                            output int nspd, output int nhc);
    int pmax, req, dir, step;
    pmax = (s > b) ? 0 : b - s;
    nst = st; nspd = spd; nhc = hc; dir = 0; step = 0;
    if (bnc != 0) begin
      dir = (st == 1) ? 1 : 2; step = SMIN; nspd = SMIN; nhc = 0;
    end else begin
      req = (ng != 0 && ps == 0) ? 1 : ((ps != 0 && ng == 0) ? 2 : 0);
      if (req != st) begin
        nst = req; nspd = SMIN; nhc = 0; dir = req; step = SMIN;
      end else if (st != 0) begin
        dir = st; step = spd; nhc = hc + 1;
        if (nhc == ACC) begin
          nhc = 0;
          nspd = (spd + 1 > SMAX) ? SMAX : spd + 1;
        end
      end
    end
    np = p;
    if (dir == 1) np = (p - step < 0) ? 0 : p - step;
    else if (dir == 2) np = (p + step > pmax) ? pmax : p + step;
    if (bnc != 0) nst = (dir == 1 && np == 0) ? 2 : ((dir == 2 && np == pmax) ? 1 : dir);
  endtask

  task automatic step(input bit tk, input bit ld, input bit en);
    int nx, ny, nsx, nsy, nhx, nhy, nstx, nsty, ey;
    exp_t e;
    tick = tk; load = ld; enable = en;
    if (ld) begin
      mx = int'(firstX); my = int'(firstY); sx = SMIN; sy = SMIN;
      hx = 0; hy = 0; stx = 0; sty = 0;
    end else if (en && tk) begin
      model_axis(mx, int'(xSize), RB, int'(mode[0]), int'(left), int'(right), stx, sx, hx,
                 nx, nstx, nsx, nhx);
      model_axis(my, int'(ySize), BB, int'(mode[1]), int'(up), int'(down), sty, sy, hy,
                 ny, nsty, nsy, nhy);
      mx = nx; stx = nstx; sx = nsx; hx = nhx;
      my = ny; sty = nsty; sy = nsy; hy = nhy;
    end
    e = '{mx, my, sx, sy};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0;
    e = sbq.pop_front();
    check("myX", int'(myX), e.x);
    check("myY", int'(myY), e.y);
    check("speedX", int'(speedX), e.sx);
    check("speedY", int'(speedY), e.sy);
    check("atLeft", int'(atLeft), int'(e.x == 0));
    check("atRight", int'(atRight), int'(e.x == RB - int'(xSize)));
    check("atTop", int'(atTop), int'(e.y == 0));
    check("atBottom", int'(atBottom), int'(e.y == BB - int'(ySize)));
    ey = int'(int'(X) >= e.x && int'(X) <= e.x + int'(xSize) &&
              int'(Y) >= e.y && int'(Y) <= e.y + int'(ySize));
    check("yes", int'(yes), ey);
  endtask

  int bexp[4] = '{698, 699, 698, 697};

  initial begin
    model_reset();
    #12;
    check("rst_myX", int'(myX), 384);
    check("rst_myY", int'(myY), 284);
    check("rst_speedX", int'(speedX), 1);
    check("rst_speedY", int'(speedY), 1);
    check("rst_yes_in", int'(yes), 1);
    X = 11'd405;
    #1;
    check("rst_yes_out", int'(yes), 0);
    X = 11'd384;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // acceleration: steps 1,1,1,1,1,2,2,2,2,3
    ySize = 9'd50; down = 1'b1;
    repeat (10) step(1'b1, 1'b0, 1'b1);
    check("acc_myY", int'(myY), 300);
    check("acc_speedY", int'(speedY), 3);
    down = 1'b0;
    step(1'b1, 1'b0, 1'b1);

    // clamp at the bottom border while at full speed
    firstY = 11'd432;
    step(1'b0, 1'b1, 1'b1);
    down = 1'b1;
    repeat (29) step(1'b1, 1'b0, 1'b1);
    check("clamp_pre_myY", int'(myY), 545);
    check("clamp_pre_speedY", int'(speedY), 8);
    step(1'b1, 1'b0, 1'b1);
    check("clamp_myY", int'(myY), 549);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check("clamp_hold_myY", int'(myY), 549);
    check("clamp_speedY", int'(speedY), 8);
    check("clamp_atBottom", int'(atBottom), 1);

    // conflicting buttons, then reversal
    up = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check("conf_myY", int'(myY), 549);
    check("conf_speedY", int'(speedY), 1);
    down = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    check("rev_myY", int'(myY), 548);
    up = 1'b0;

    // bounce on X, buttons toggling
    mode = 2'b01; xSize = 9'd100; firstX = 11'd697;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      left = (i % 2) == 0; right = (i % 2) != 0;
      step(1'b1, 1'b0, 1'b1);
      check("bounce_myX", int'(myX), bexp[i]);
      check("bounce_atRight", int'(atRight), int'(i == 1));
    end
    mode = 2'b00; left = 1'b0; right = 1'b0;

    // enable low freezes everything
    right = 1'b1; down = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("frz_myX", int'(myX), 697);

    // load wins over tick
    firstX = 11'd10;
    step(1'b1, 1'b1, 1'b1);
    check("ld_myX", int'(myX), 10);
    check("ld_speedX", int'(speedX), 1);

    // asynchronous reset mid-acceleration
    right = 1'b0;
    repeat (17) step(1'b1, 1'b0, 1'b1);
    check("pre_rst_speedY", int'(speedY), 5);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_myX", int'(myX), 384);
    check("arst_myY", int'(myY), 284);
    check("arst_speedY", int'(speedY), 1);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check("post_rst_myY", int'(myY), 285);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
